// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer sitting behind the CPU system bridge.
//
// Registers (word index = addr[3:2]):
//   0 CTRL   R/W  bit0 EN, bits[2:1] MODE (01 auto-reload, else one-shot), bit3 IM
//   1 PRESET R/W  reload value (COUNT_WIDTH bits, zero-extended on read)
//   2 COUNT  RO   current countdown value
//   3 --     reads 0, writes ignored
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   addr   byte address from the bridge (only [3:2] decoded)
//   we     device write strobe from the bridge
//   wd     write data
//   rd     combinational read data for addr[3:2]
//   irq    interrupt request = CTRL.IM & irq_flag
module timer_dev #(
  parameter int COUNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;

  state_e                 state_q, state_d;
  logic                   en_q, en_d;
  logic [1:0]             mode_q, mode_d;
  logic                   im_q, im_d;
  logic [COUNT_WIDTH-1:0] preset_q, preset_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   irq_flag_q, irq_flag_d;

  logic wr_ctrl, wr_preset, auto_mode, cnt_expire;
  logic unused_addr_bits;

  assign wr_ctrl    = we && (addr[3:2] == 2'd0);
  assign wr_preset  = we && (addr[3:2] == 2'd1);
  assign auto_mode  = (mode_q == 2'b01);
  // COUNT<=1 also covers PRESET=0, which therefore behaves like PRESET=1.
  assign cnt_expire = (state_q == S_CNT) && en_q && (count_q <= COUNT_WIDTH'(1));
  assign unused_addr_bits = ^{addr[31:4], addr[1:0]};

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      en_q       <= 1'b0;
      mode_q     <= 2'b00;
      im_q       <= 1'b0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      im_q       <= im_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  // Next-state logic; evaluates pre-edge register values only.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (en_q) state_d = S_LOAD;
      S_LOAD: state_d = S_CNT;
      S_CNT: begin
        if (!en_q)           state_d = S_IDLE;
        else if (cnt_expire) state_d = S_INT;
      end
      S_INT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Register updates: FSM actions first, CPU writes layered on top where
  // the CPU is meant to win.
  always_comb begin
    en_d       = en_q;
    mode_d     = mode_q;
    im_d       = im_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    // One-shot: any CTRL/PRESET write acknowledges the interrupt.
    if (!auto_mode && (wr_ctrl || wr_preset)) irq_flag_d = 1'b0;

    unique case (state_q)
      S_LOAD: count_d = preset_q;
      S_CNT: begin
        if (en_q) begin
          if (cnt_expire) begin
            count_d    = '0;
            irq_flag_d = 1'b1;   // set beats a same-edge CPU clear
          end else begin
            count_d = count_q - COUNT_WIDTH'(1);
          end
        end
      end
      S_INT: begin
        if (auto_mode) begin
          irq_flag_d = 1'b0;
        end else begin
          en_d       = 1'b0;
          // Flag is still being asserted on this edge, so it survives a
          // colliding CPU write.
          irq_flag_d = 1'b1;
        end
      end
      default: ;
    endcase

    // A CPU CTRL write overrides the one-shot EN clear.
    if (wr_ctrl) begin
      en_d   = wd[0];
      mode_d = wd[2:1];
      im_d   = wd[3];
    end
    if (wr_preset) preset_d = wd[COUNT_WIDTH-1:0];
  end

  // Outputs: purely from registered state (rd additionally from addr).
  always_comb begin
    rd = '0;
    unique case (addr[3:2])
      2'd0: rd[3:0] = {im_q, mode_q, en_q};
      2'd1: rd[COUNT_WIDTH-1:0] = preset_q;
      2'd2: rd[COUNT_WIDTH-1:0] = count_q;
      default: rd = '0;
    endcase
    irq = im_q & irq_flag_q;
  end

endmodule

// File: tb/tb_timer_dev.sv
module tb_timer_dev;

  logic        clk, reset, we, irq;
  logic [31:0] addr, wd, rd;

  timer_dev #(.COUNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we), .wd(wd), .rd(rd), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // Phases: 0 idle, 1 load, 2 counting, 3 interrupt
  int          m_ph;
  bit          m_en, m_im, m_flag;
  bit   [1:0]  m_mode;
  logic [31:0] m_preset, m_count;

  task automatic model_reset();
    m_ph = 0; m_en = 0; m_im = 0; m_flag = 0; m_mode = 0;
    m_preset = 0; m_count = 0;
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    case (a[3:2])
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step(input logic [31:0] a, input logic w, input logic [31:0] d);
    bit auto_m = (m_mode == 2'b01);
    bit w_ctrl = w && (a[3:2] == 2'd0);
    bit w_pre  = w && (a[3:2] == 2'd1);
    int          nph  = m_ph;
    bit          nen  = m_en;
    bit          nflg = m_flag;
    logic [31:0] ncnt = m_count;
    bit fsm_sets = 0;
    if (m_ph == 0) begin
      if (m_en) nph = 1;
    end else if (m_ph == 1) begin
      ncnt = m_preset; nph = 2;
    end else if (m_ph == 2) begin
      if (!m_en) nph = 0;
      else if (m_count > 1) ncnt = m_count - 1;
      else begin ncnt = 0; fsm_sets = 1; nph = 3; end
    end else begin
      nph = 0;
      if (auto_m) nflg = 0;
      else begin nen = 0; fsm_sets = 1; end
    end
    if (fsm_sets) nflg = 1;
    else if (!auto_m && (w_ctrl || w_pre)) nflg = 0;
    if (w_ctrl) begin nen = d[0]; m_mode = d[2:1]; m_im = d[3]; end
    if (w_pre) m_preset = d;
    m_ph = nph; m_en = nen; m_flag = nflg; m_count = ncnt;
  endtask

  // One bus cycle: apply, clock, then compare DUT to model 1 time unit later.
  task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d);
    addr = a; we = w; wd = d;
    @(posedge clk);
    model_step(a, w, d);
    #1;
    chk("model_rd", rd, model_rd(a));
    chk("model_irq", {31'd0, irq}, {31'd0, m_flag & m_im});
    we = 1'b0;
  endtask

  task automatic do_reset();
    addr = 0; we = 0; wd = 0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic        w;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[20];
  bit   irq_log[40];
  logic [31:0] cnt_log[40];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // one-shot then decode checks, starting right after reset
    tbl[0]  = '{32'h4, 1'b1, 32'h5,        32'h5, 1'b0};
    tbl[1]  = '{32'h0, 1'b1, 32'h9,        32'h9, 1'b0};
    tbl[2]  = '{32'h8, 1'b0, 32'h0,        32'h0, 1'b0};
    tbl[3]  = '{32'h8, 1'b0, 32'h0,        32'h5, 1'b0};
    tbl[4]  = '{32'h8, 1'b0, 32'h0,        32'h4, 1'b0};
    tbl[5]  = '{32'h8, 1'b0, 32'h0,        32'h3, 1'b0};
    tbl[6]  = '{32'h8, 1'b0, 32'h0,        32'h2, 1'b0};
    tbl[7]  = '{32'h8, 1'b0, 32'h0,        32'h1, 1'b0};
    tbl[8]  = '{32'h8, 1'b0, 32'h0,        32'h0, 1'b1};
    tbl[9]  = '{32'h0, 1'b0, 32'h0,        32'h8, 1'b1};
    tbl[10] = '{32'h0, 1'b0, 32'h0,        32'h8, 1'b1};
    tbl[11] = '{32'h0, 1'b1, 32'h0,        32'h0, 1'b0};
    tbl[12] = '{32'h0, 1'b1, 32'hFFFFFFFF, 32'hF, 1'b0};
    tbl[13] = '{32'h0, 1'b1, 32'h0,        32'h0, 1'b0};
    tbl[14] = '{32'h8, 1'b0, 32'h0,        32'h5, 1'b0};
    tbl[15] = '{32'h8, 1'b1, 32'h55,       32'h5, 1'b0};
    tbl[16] = '{32'hC, 1'b1, 32'h1234,     32'h0, 1'b0};
    tbl[17] = '{32'h4, 1'b0, 32'h77,       32'h5, 1'b0};
    tbl[18] = '{32'h0, 1'b0, 32'hF,        32'h0, 1'b0};
    tbl[19] = '{32'h8, 1'b0, 32'h0,        32'h5, 1'b0};

    do_reset();
    chk("reset_ctrl", rd, 32'h0);
    chk("reset_irq", {31'd0, irq}, 32'd0);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].a, tbl[i].w, tbl[i].d);
      chk($sformatf("vec%0d_rd", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].exp_irq});
    end

    // ---- auto-reload: PRESET=3, CTRL=0xB ----
    do_reset();
    drive(32'h4, 1'b1, 32'd3);
    drive(32'h0, 1'b1, 32'hB);
    for (int i = 0; i < 40; i++) begin
      drive(32'h8, 1'b0, 32'd0);
      irq_log[i] = irq;
      cnt_log[i] = rd;
    end
    begin
      int pulses = 0, last = -1;
      for (int i = 3; i < 39; i++) begin
        if (irq_log[i]) begin
          pulses++;
          chk("ar_width", {31'd0, irq_log[i+1]}, 32'd0);
          chk("ar_seq3", cnt_log[i-3], 32'd3);
          chk("ar_seq0", cnt_log[i], 32'd0);
          if (last >= 0) chk("ar_period", i - last, 32'd6);
          last = i;
        end
      end
      chk("ar_pulses_ge3", {31'd0, pulses >= 3}, 32'd1);
    end

    // ---- mask and pause ----
    do_reset();
    drive(32'h4, 1'b1, 32'd4);
    drive(32'h0, 1'b1, 32'h3);
    begin
      bit seen_irq = 0, seen_one = 0, found = 0;
      for (int i = 0; i < 20; i++) begin
        drive(32'h8, 1'b0, 32'd0);
        if (irq) seen_irq = 1;
        if (rd == 32'd1) seen_one = 1;
      end
      chk("mask_no_irq", {31'd0, seen_irq}, 32'd0);
      chk("mask_counts", {31'd0, seen_one}, 32'd1);
      for (int i = 0; i < 20 && !found; i++) begin
        drive(32'h8, 1'b0, 32'd0);
        if (rd == 32'd3) found = 1;
      end
      chk("pause_wait3", {31'd0, found}, 32'd1);
      drive(32'h0, 1'b1, 32'h2);
      for (int i = 0; i < 10; i++) begin
        drive(32'h8, 1'b0, 32'd0);
        chk("pause_frozen", rd, 32'd2);
      end
      drive(32'h0, 1'b1, 32'h3);
      drive(32'h8, 1'b0, 32'd0);
      drive(32'h8, 1'b0, 32'd0);
      chk("pause_restart", rd, 32'd4);
    end

    // ---- collision: CTRL=0x9 written on the INT edge (one-shot) ----
    do_reset();
    drive(32'h4, 1'b1, 32'd2);
    drive(32'h0, 1'b1, 32'h9);
    begin
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        drive(32'h8, 1'b0, 32'd0);
        if (irq) got = 1;
      end
      chk("coll_wait_irq", {31'd0, got}, 32'd1);
    end
    drive(32'h0, 1'b1, 32'h9);
    chk("coll_ctrl", rd, 32'h9);
    chk("coll_irq", {31'd0, irq}, 32'd1);
    drive(32'h8, 1'b0, 32'd0);
    drive(32'h8, 1'b0, 32'd0);
    chk("coll_reload", rd, 32'd2);
    chk("coll_irq_hold", {31'd0, irq}, 32'd1);

    // ---- reset mid-count ----
    do_reset();
    drive(32'h4, 1'b1, 32'd100);
    drive(32'h0, 1'b1, 32'h9);
    repeat (10) drive(32'h8, 1'b0, 32'd0);
    #2 reset = 1'b1;
    model_reset();
    for (int a = 0; a < 4; a++) begin
      addr = 32'(a) << 2;
      #1;
      chk($sformatf("rst_rd%0d", a), rd, 32'd0);
    end
    chk("rst_irq", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) begin
      drive(32'h8, 1'b0, 32'd0);
      chk("rst_count_idle", rd, 32'd0);
    end

    // ---- randomized traffic against the model ----
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r, a, d;
      logic [1:0]  reg_sel;
      logic        w;
      r = $urandom;
      reg_sel = 2'($urandom_range(0, 3));
      a = {r[31:4], reg_sel, r[1:0]};
      w = ($urandom_range(0, 5) == 0);
      d = $urandom;
      if (reg_sel == 2'd0) d[0] = ($urandom_range(0, 3) != 0);
      if (reg_sel == 2'd1 && $urandom_range(0, 19) != 0) d = $urandom_range(0, 6);
      drive(a, w, d);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
